// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide producing a 2*WIDTH result; define MULDIV_BOOTH4_EN for radix-4 Booth multiply
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               op,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               dz,
  output logic [2*WIDTH-1:0] z_out
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2*W-1:0] acc, div_step, mul_step, fix_mul;
  logic [W-1:0] bm, ma, mb, q, r;
  logic [CW-1:0] cnt;
  logic op_r, sa, sb, neg, last, by_zero;
  logic [W:0] drem, ddif;
  assign ma = (sgn && a[W-1]) ? -a : a;
  assign mb = (sgn && b[W-1]) ? -b : b;
  assign last = cnt == CW'(1);
  assign by_zero = op_r && bm == '0;
  assign neg = sa ^ sb;
  assign q = acc[W-1:0];
  assign r = acc[2*W-1:W];
  assign drem = {acc[2*W-1:W], acc[W-1]};
  assign ddif = drem - {1'b0, bm};
  assign div_step = ddif[W] ? {drem[W-1:0], acc[W-2:0], 1'b0} : {ddif[W-1:0], acc[W-2:0], 1'b1};
`ifdef MULDIV_BOOTH4_EN
  logic [2*W-1:0] mc, badd, bext;
  logic [W:0] mq;
  logic ucorr;
  logic [2:0] trip;
  assign trip = mq[2:0];
  assign badd = (trip == 3'b011) ? (mc << 1) :
                (trip == 3'b100) ? -(mc << 1) :
                (trip == 3'b001 || trip == 3'b010) ? mc :
                (trip == 3'b101 || trip == 3'b110) ? -mc : '0;
  assign bext = (last && ucorr) ? (mc << 2) : '0;
  assign mul_step = acc + badd + bext;
  assign fix_mul = acc;
  // Booth operand shifters; unsigned multipliers with the top bit set get a final +a*2^W correction
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mc <= '0;
      mq <= '0;
      ucorr <= 1'b0;
    end else if (state == IDLE && start) begin
      mc <= {{W{sgn & a[W-1]}}, a};
      mq <= {b, 1'b0};
      ucorr <= !sgn && b[W-1];
    end else if (state == RUN) begin
      mc <= mc << 2;
      mq <= mq >> 2;
    end
  end
`else
  logic [W:0] msum;
  assign msum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, bm} : '0);
  assign mul_step = {msum, acc[W-1:1]};
  assign fix_mul = neg ? -acc : acc;
`endif
  // state register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else state <= state_nx;
  end
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? RUN : IDLE;
      RUN:  state_nx = by_zero ? DONE : (last ? FIX : RUN);
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end
  // status outputs decoded from state
  always_comb begin
    busy = state == RUN || state == FIX;
    done = state == DONE;
  end
  // datapath: operand capture, iteration, sign fix-up and result latch
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      acc <= '0;
      bm <= '0;
      cnt <= '0;
      op_r <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      z_out <= '0;
    end else if (state == IDLE && start) begin
      op_r <= op;
      sa <= sgn & a[W-1];
      sb <= sgn & b[W-1];
      bm <= mb;
      dz <= 1'b0;
`ifdef MULDIV_BOOTH4_EN
      acc <= op ? {{W{1'b0}}, ma} : '0;
      cnt <= op ? CW'(W) : CW'(W / 2);
`else
      acc <= {{W{1'b0}}, ma};
      cnt <= CW'(W);
`endif
    end else if (state == RUN) begin
      if (by_zero) begin
        z_out <= {sa ? -q : q, {W{1'b1}}};
        dz <= 1'b1;
      end else begin
        acc <= op_r ? div_step : mul_step;
        cnt <= cnt - CW'(1);
      end
    end else if (state == FIX) begin
      z_out <= op_r ? {sa ? -r : r, neg ? -q : q} : fix_mul;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
  localparam int W = 32;
`ifdef MULDIV_BOOTH4_EN
  localparam int MUL_LAT = W / 2 + 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  logic clock = 1'b0, clear = 1'b0, start = 1'b0, op = 1'b0, sgn = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, dz;
  logic [2*W-1:0] z_out;
  typedef struct {
    logic [63:0] z;
    logic dz;
    int cyc;
    string name;
  } exp_t;
  exp_t sb[$];
  exp_t got;
  int errors = 0, checks = 0, cyc = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .sgn(sgn),
    .a(a), .b(b), .busy(busy), .done(done), .dz(dz), .z_out(z_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [64:0] model(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, rm;
    sx = s ? {{32{x[31]}}, x} : {32'b0, x};
    sy = s ? {{32{y[31]}}, y} : {32'b0, y};
    if (!o) return {1'b0, 64'(sx * sy)};
    if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
    q = sx / sy;
    rm = sx % sy;
    return {1'b0, rm[31:0], q[31:0]};
  endfunction

  // monitor: every done pulse is matched against the oldest expectation
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got z=%h expected no done", z_out);
      end else begin
        got = sb.pop_front();
        chk({got.name, "_z"}, z_out, got.z);
        chk({got.name, "_dz"}, 64'(dz), 64'(got.dz));
        chk({got.name, "_lat"}, 64'(cyc), 64'(got.cyc));
      end
    end
  end

  task automatic do_op(input string nm, input logic o, input logic s, input logic [31:0] x, input logic [31:0] y, input bit hazard);
    exp_t e;
    int n;
    @(negedge clock);
    op = o; sgn = s; a = x; b = y; start = 1'b1;
    {e.dz, e.z} = model(o, s, x, y);
    e.cyc = cyc + 1 + ((o && y == 0) ? 1 : (o ? W + 1 : MUL_LAT));
    e.name = nm;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1); sgn = $urandom_range(0, 1);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    chk({nm, "_dzclr"}, 64'(dz), 64'd0);
    if (hazard) begin
      repeat (4) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", nm);
      sb.delete();
    end
    @(negedge clock);
    chk({nm, "_hold"}, z_out, e.z);
  endtask

  initial begin
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_z", z_out, 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    do_op("umul", 0, 0, 32'h0000_FFFF, 32'h0001_0001, 0);
    do_op("smul", 0, 1, 32'hFFFF_FFFD, 32'd7, 0);
    do_op("sdiv", 1, 1, -32'sd17, 32'd5, 0);
    do_op("udiv", 1, 0, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("sdiv_ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("div0", 1, 0, 32'd100, 32'd0, 0);
    chk("dz_hold", 64'(dz), 64'd1);
    do_op("smul_min", 0, 1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op("umul_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("smul_mix", 0, 1, 32'h8000_0001, 32'hFFFF_FFFF, 0);
    do_op("sdiv_nn", 1, 1, -32'sd100, -32'sd7, 0);
    do_op("sdiv0", 1, 1, -32'sd9, 32'd0, 0);
    do_op("hz_mul", 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    do_op("hz_div", 1, 1, 32'h8765_4321, 32'd12345, 1);
    for (int i = 0; i < 40; i++) begin
      logic o, s;
      logic [31:0] x, y;
      o = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom);
      do_op($sformatf("rnd%0d", i), o, s, x, y, !(o && y == 0) && $urandom_range(0, 3) == 0);
    end
    @(negedge clock);
    op = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    @(posedge clock);
    #2 clear = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_z", z_out, 64'd0);
    chk("abort_dz", 64'(dz), 64'd0);
    @(negedge clock);
    clear = 1'b1;
    repeat (45) @(negedge clock);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    chk("abort_idle_z", z_out, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end
endmodule
